// File: rtl/puf_pkg.sv
// Shared types, default sizing and the vote helper for the PUF response collector.
// Optional stability monitor is enabled by defining PUF_STABILITY_MON_EN.
package puf_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StCommit,
      StDone
   } puf_col_state_t;

   localparam int unsigned PUF_RESP_BITS = 32;
   localparam int unsigned PUF_VOTES     = 5;

   function automatic logic puf_majority(input int unsigned ones, input int unsigned votes);
      return ones > (votes / 2);
   endfunction

endpackage

// File: rtl/puf_vote_counter.sv
// Per-bit vote accumulator: counts strobes and ones for the bit currently being evaluated.
// With PUF_STABILITY_MON_EN defined it also reports whether all votes agreed.
module puf_vote_counter
   import puf_pkg::*;
#(
   parameter int unsigned VOTES = PUF_VOTES,
   parameter int unsigned CNT_W = $clog2(VOTES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic sample,
   input  logic bit_in,
   output logic done,
   output logic voted
`ifdef PUF_STABILITY_MON_EN
   ,
   output logic unanimous
`endif
);

   logic [CNT_W-1:0] samp_cnt;
   logic [CNT_W-1:0] ones_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_cnt <= '0;
         ones_cnt <= '0;
      end else if (clear) begin
         samp_cnt <= '0;
         ones_cnt <= '0;
      end else if (sample) begin
         samp_cnt <= samp_cnt + CNT_W'(1);
         ones_cnt <= ones_cnt + CNT_W'(bit_in);
      end
   end

   // Flags the strobe that completes the vote, so the FSM can leave COLLECT on that edge.
   assign done  = sample && (samp_cnt == CNT_W'(VOTES - 1));
   assign voted = puf_majority(32'(ones_cnt), VOTES);

`ifdef PUF_STABILITY_MON_EN
   assign unanimous = (ones_cnt == '0) || (ones_cnt == CNT_W'(VOTES));
`endif

endmodule

// File: rtl/puf_response_collector.sv
// Sequences RO-pair selection, majority-votes repeated PUF evaluations and hands out the word.
// Define PUF_STABILITY_MON_EN to count non-unanimous bits in unstable_cnt.
module puf_response_collector
   import puf_pkg::*;
#(
   parameter int unsigned RESP_BITS = PUF_RESP_BITS,
   parameter int unsigned VOTES     = PUF_VOTES,
   parameter int unsigned IDX_W     = $clog2(RESP_BITS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 puf_bit_in,
   input  logic                 puf_bit_valid,
   output logic                 eval_req,
   output logic [IDX_W-1:0]     sel_idx,
   output logic                 busy,
   output logic [RESP_BITS-1:0] resp_data,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [IDX_W:0]       unstable_cnt
);

   if ((VOTES % 2 == 0) || (VOTES < 1) || (VOTES > 15)) begin : g_bad_votes
      $error("puf_response_collector: VOTES must be odd and within 1..15");
   end

   puf_col_state_t       state;
   logic [RESP_BITS-1:0] shreg;
   logic [RESP_BITS-1:0] shreg_nxt;
   logic                 vote_clear;
   logic                 vote_sample;
   logic                 vote_done;
   logic                 voted;
   logic                 start_acc;

   assign start_acc   = (state == StIdle) && start;
   assign vote_sample = (state == StCollect) && puf_bit_valid;
   assign vote_clear  = start_acc || (state == StCommit);
   // Index 0 is shifted in first and so lands at the MSB.
   assign shreg_nxt   = {shreg[RESP_BITS-2:0], voted};

`ifdef PUF_STABILITY_MON_EN
   logic unanimous;
`endif

   puf_vote_counter #(
      .VOTES (VOTES)
   ) u_votes (
      .clk       (clk),
      .rst       (rst),
      .clear     (vote_clear),
      .sample    (vote_sample),
      .bit_in    (puf_bit_in),
      .done      (vote_done),
      .voted     (voted)
`ifdef PUF_STABILITY_MON_EN
      ,
      .unanimous (unanimous)
`endif
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= StIdle;
         sel_idx    <= '0;
         shreg      <= '0;
         resp_data  <= '0;
         resp_valid <= 1'b0;
         eval_req   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (start) begin
                  state    <= StCollect;
                  sel_idx  <= '0;
                  shreg    <= '0;
                  busy     <= 1'b1;
                  eval_req <= 1'b1;
               end
            end
            StCollect: begin
               if (vote_done) begin
                  state    <= StCommit;
                  eval_req <= 1'b0;
               end
            end
            StCommit: begin
               shreg <= shreg_nxt;
               if (sel_idx == IDX_W'(RESP_BITS - 1)) begin
                  resp_data  <= shreg_nxt;
                  resp_valid <= 1'b1;
                  state      <= StDone;
               end else begin
                  sel_idx  <= sel_idx + IDX_W'(1);
                  eval_req <= 1'b1;
                  state    <= StCollect;
               end
            end
            StDone: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

`ifdef PUF_STABILITY_MON_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         unstable_cnt <= '0;
      end else if (start_acc) begin
         unstable_cnt <= '0;
      end else if ((state == StCommit) && !unanimous &&
                   (unstable_cnt != (IDX_W + 1)'(RESP_BITS))) begin
         unstable_cnt <= unstable_cnt + (IDX_W + 1)'(1);
      end
   end
`else
   assign unstable_cnt = '0;
`endif

endmodule

// File: tb/tb_puf_response_collector.sv
// Directed bench for puf_response_collector at RESP_BITS=8, VOTES=3; acts as the PUF core.
// Expected unstable_cnt follows PUF_STABILITY_MON_EN.
module tb_puf_response_collector;

   localparam int unsigned RB = 8;
   localparam int unsigned NV = 3;
   localparam int unsigned IW = 3;

   logic          clk           = 1'b0;
   logic          rst           = 1'b1;
   logic          start         = 1'b0;
   logic          puf_bit_in    = 1'b0;
   logic          puf_bit_valid = 1'b0;
   logic          resp_ready    = 1'b1;
   logic          eval_req;
   logic [IW-1:0] sel_idx;
   logic          busy;
   logic [RB-1:0] resp_data;
   logic          resp_valid;
   logic [IW:0]   unstable_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   puf_response_collector #(
      .RESP_BITS (RB),
      .VOTES     (NV)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .puf_bit_in    (puf_bit_in),
      .puf_bit_valid (puf_bit_valid),
      .eval_req      (eval_req),
      .sel_idx       (sel_idx),
      .busy          (busy),
      .resp_data     (resp_data),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .unstable_cnt  (unstable_cnt)
   );

   // Each response bit i (MSB = bit 0) repeated in all three votes.
   function automatic logic [23:0] build(input logic [7:0] w);
      logic [23:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[3*i +: 3] = {3{w[7-i]}};
      return r;
   endfunction

   task automatic start_pulse(output int t0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t0 = cyc;
      vectors++;
      if (busy !== 1'b1 || eval_req !== 1'b1) begin
         miscompares++;
         $display("FAIL start_timing: busy=%b eval_req=%b required 1 1", busy, eval_req);
      end
   endtask

   // Strobe k carries v[k]; strobes only while eval_req is seen high.
   task automatic drive_votes(input logic [23:0] v, input int n, input int max_gap);
      int waits;
      int gap;
      for (int k = 0; k < n; k++) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         repeat (gap) begin
            puf_bit_valid = 1'b0;
            @(negedge clk);
         end
         waits = 0;
         while (!eval_req && waits < 200) begin
            puf_bit_valid = 1'b0;
            @(negedge clk);
            waits++;
         end
         if (eval_req !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL eval_req_timeout strobe %0d: eval_req=%b required 1", k, eval_req);
            puf_bit_valid = 1'b0;
            return;
         end
         vectors++;
         if (sel_idx !== IW'(k / NV)) begin
            miscompares++;
            $display("FAIL sel_idx strobe %0d: got %0d required %0d", k, sel_idx, k / NV);
         end
         puf_bit_valid = 1'b1;
         puf_bit_in    = v[k];
         @(negedge clk);
         if (k % NV == NV - 1) begin
            vectors++;
            if (eval_req !== 1'b0 || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL commit_eval_req bit %0d: eval_req=%b busy=%b required 0 1",
                        k / NV, eval_req, busy);
            end
         end
      end
      puf_bit_valid = 1'b0;
   endtask

   task automatic wait_response(input logic [7:0] exp_data, input logic [3:0] exp_unst,
                                output int t1);
      int waits;
      waits = 0;
      while (resp_valid !== 1'b1 && waits < 500) begin
         @(negedge clk);
         waits++;
      end
      t1 = cyc;
      vectors++;
      if (resp_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL resp_valid_timeout: resp_valid=%b required 1", resp_valid);
      end
      vectors++;
      if (resp_data !== exp_data) begin
         miscompares++;
         $display("FAIL resp_data: got %h required %h", resp_data, exp_data);
      end
      vectors++;
      if (unstable_cnt !== exp_unst) begin
         miscompares++;
         $display("FAIL unstable_cnt: got %0d required %0d", unstable_cnt, exp_unst);
      end
      if (resp_ready) begin
         @(negedge clk);
         vectors++;
         if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL handoff: resp_valid=%b busy=%b required 0 0", resp_valid, busy);
         end
      end
   endtask

   task automatic test_reset();
      int t0;
      int t1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({eval_req, sel_idx, busy, resp_data, resp_valid, unstable_cnt} !== 18'd0) begin
         miscompares++;
         $display("FAIL reset_values: req=%b idx=%0d busy=%b data=%h valid=%b unst=%0d required 0",
                  eval_req, sel_idx, busy, resp_data, resp_valid, unstable_cnt);
      end
      rst = 1'b0;
      start_pulse(t0);
      drive_votes(24'hFFFFFF, 13, 0);
      rst = 1'b1;
      #1;
      vectors++;
      if ({eval_req, sel_idx, busy, resp_data, resp_valid, unstable_cnt} !== 18'd0) begin
         miscompares++;
         $display("FAIL reset_mid_collect: req=%b idx=%0d busy=%b data=%h valid=%b unst=%0d required 0",
                  eval_req, sel_idx, busy, resp_data, resp_valid, unstable_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      start_pulse(t0);
      drive_votes(build(8'hA5), 24, 0);
      wait_response(8'hA5, 4'd0, t1);
   endtask

   task automatic test_all_ones();
      int t0;
      int t1;
      start_pulse(t0);
      drive_votes(24'hFFFFFF, 24, 0);
      wait_response(8'hFF, 4'd0, t1);
      vectors++;
      if (t1 - t0 + 1 != 33) begin
         miscompares++;
         $display("FAIL latency: got %0d cycles required 33", t1 - t0 + 1);
      end
   endtask

   task automatic test_alternating();
      int t0;
      int t1;
      start_pulse(t0);
      drive_votes(24'b111000111000111000111000, 24, 0);
      wait_response(8'h55, 4'd0, t1);
   endtask

   task automatic test_majority();
      int t0;
      int t1;
      logic [3:0] exp_u;
`ifdef PUF_STABILITY_MON_EN
      exp_u = 4'd2;
`else
      exp_u = 4'd0;
`endif
      // bit 0 votes 1,0,1 ; bit 1 votes 0,1,0 ; rest all zero
      start_pulse(t0);
      drive_votes(24'h000015, 24, 0);
      wait_response(8'h80, exp_u, t1);
   endtask

   task automatic test_backpressure();
      int t0;
      int t1;
      resp_ready = 1'b0;
      start_pulse(t0);
      drive_votes(24'b111000111000111000111000, 24, 0);
      wait_response(8'h55, 4'd0, t1);
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if (resp_valid !== 1'b1 || resp_data !== 8'h55 || busy !== 1'b1 || eval_req !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_hold cycle %0d: valid=%b data=%h busy=%b req=%b required 1 55 1 0",
                     i, resp_valid, resp_data, busy, eval_req);
         end
         start         = 1'b1;
         puf_bit_valid = 1'b1;
         puf_bit_in    = 1'b0;
         @(negedge clk);
      end
      start         = 1'b0;
      puf_bit_valid = 1'b0;
      resp_ready    = 1'b1;
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b0 || busy !== 1'b0 || eval_req !== 1'b0) begin
         miscompares++;
         $display("FAIL backpressure_release: valid=%b busy=%b req=%b required 0 0 0",
                  resp_valid, busy, eval_req);
      end
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL backpressure_idle: valid=%b busy=%b required 0 0", resp_valid, busy);
      end
   endtask

   task automatic test_strobe_gaps();
      int t0;
      int t1;
      start_pulse(t0);
      drive_votes(24'b111000111000111000111000, 24, 7);
      wait_response(8'h55, 4'd0, t1);
      start_pulse(t0);
      drive_votes(build(8'hA5), 24, 7);
      wait_response(8'hA5, 4'd0, t1);
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_alternating();
      test_majority();
      test_backpressure();
      test_strobe_gaps();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/puf_response_collector.md
# puf_response_collector

Downstream consumer of the ring-oscillator PUF core's `puf_bit_out`. Drives the RO-pair select index, takes `VOTES` repeated evaluations per challenge bit, majority-votes them into one stable bit, and assembles `RESP_BITS` voted bits into a response word. The word is handed to the key/ID logic over a valid/ready handshake.

## Interface
- `RESP_BITS`, 32: response word width; also the number of RO-pair selections per response.
- `VOTES`, 5: evaluations per bit; odd, 1..15.
- `IDX_W`, `$clog2(RESP_BITS)`: select index width.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset; one clock domain.
- `start` in 1: one-cycle request to begin a response; sampled only in IDLE.
- `puf_bit_in` in 1: PUF comparison result.
- `puf_bit_valid` in 1: one-cycle strobe; `puf_bit_in` is valid on this cycle.
- `eval_req` out 1: asks the PUF core to run a comparison; high in COLLECT.
- `sel_idx` out IDX_W: RO-pair/challenge index for the current bit.
- `busy` out 1: high in any state other than IDLE.
- `resp_data` out RESP_BITS: assembled response word.
- `resp_valid` out 1: response word is available.
- `resp_ready` in 1: consumer accepts the word.
- `unstable_cnt` out IDX_W+1: number of non-unanimous bits in the last response.

## Operation
- FSM states: IDLE, COLLECT, COMMIT, DONE.
- IDLE: on `start`, clear the vote counters, `sel_idx`, shift register and `unstable_cnt`, then go to COLLECT.
- COLLECT: each `puf_bit_valid` increments `samp_cnt` and adds `puf_bit_in` to `ones_cnt`. Both counters are `$clog2(VOTES+1)` bits wide. On the strobe that makes `samp_cnt`==VOTES, go to COMMIT.
- COMMIT, one cycle:
  - Compute the voted bit: 1 when `ones_cnt` > VOTES/2 (integer division).
  - Shift it in: `shreg <= {shreg[RESP_BITS-2:0], voted}`. Index 0's bit ends up at the MSB.
  - Clear both vote counters.
  - If `sel_idx`==RESP_BITS-1, load `resp_data` from the new shift value and go to DONE.
  - Otherwise increment `sel_idx` and return to COLLECT.
- DONE: `resp_valid`=1. `resp_data` and `unstable_cnt` hold steady. When `resp_valid && resp_ready`, go to IDLE the next cycle; `resp_valid` drops.
- Ignored inputs: `puf_bit_valid` outside COLLECT, and `start` outside IDLE.
- `resp_ready` may be high before `resp_valid`. The transfer happens on the first DONE cycle.
- Reset at any time: state IDLE, all counters and registers 0. Any partial response is discarded.

## Timing
- Reset values: `eval_req`=0, `sel_idx`=0, `busy`=0, `resp_data`=0, `resp_valid`=0, `unstable_cnt`=0.
- `start` at edge N sets `busy` and `eval_req` after edge N.
- Last vote of a bit at edge M: COMMIT during cycle M+1, and `eval_req` is low in that cycle. The next bit's `sel_idx` is visible after edge M+1.
- Last vote of the final bit at edge M: `resp_valid` is high after edge M+1.
- Minimum latency: RESP_BITS×(VOTES+1)+1 cycles from `start` to `resp_valid`, with strobes every cycle.
- All outputs are registered. No combinational path from input to output.

## Configuration
- `PUF_STABILITY_MON_EN` defined:
  - In COMMIT, `unstable_cnt` increments when `ones_cnt` is neither 0 nor VOTES.
  - It saturates at RESP_BITS and clears on `start`.
- Not defined: `unstable_cnt` is tied to 0 and no monitor logic is built.

## Structure
- Package `puf_pkg` holds:
  - the state enum `puf_col_state_t`;
  - the default constants `PUF_RESP_BITS`=32 and `PUF_VOTES`=5;
  - the function `puf_majority(ones, votes)`.
- Sub-module `puf_vote_counter`:
  - holds `samp_cnt` and `ones_cnt`, and the `done` and `voted` outputs;
  - with the monitor compiled in, also the `unanimous` output;
  - is cleared by the FSM.
- Elaboration assertion: VOTES is odd and between 1 and 15.

## Test plan
All scenarios use RESP_BITS=8 and VOTES=3.
- Reset values: assert `rst` mid-COLLECT at bit 4 → all outputs 0 and `busy`=0 on the same cycle. A following `start` produces a fresh response.
- All-ones response: bits always 1, strobe every cycle → `resp_data`=8'hFF, `resp_valid` 33 cycles after `start`, `unstable_cnt`=0.
- Alternating pattern: for bit i, return i[0] in all three votes → `resp_data`=8'h55. `sel_idx` steps 0..7, one step per COMMIT.
- Majority voting: bit 0 gets votes 1,0,1 and bit 1 gets 0,1,0; the other bits get 0,0,0 → `resp_data`=8'h80. `unstable_cnt`=2 with the macro, 0 without.
- Backpressure: `resp_ready` low for 10 cycles in DONE → `resp_valid` and `resp_data` stable. Strobes and `start` during that time have no effect. Raising `resp_ready` gives one transfer, then IDLE.
- Strobe gaps: random 0–7 cycle gaps between `puf_bit_valid` pulses → same `resp_data` as with back-to-back strobes. No sample is lost or double-counted.
